// File: rtl/udp_recv.sv
// udp_recv: byte-wide Ethernet/IPv4/UDP receiver with MAC/IP/port filtering and payload streaming.
// Define UDP_RECV_FCS_CHECK_EN to validate the Ethernet FCS before reporting o_ok.
module udp_recv #(
  parameter int MAX_PAYLOAD  = 1472,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic [47:0] i_local_mac,
  input  logic [31:0] i_local_ip,
  input  logic [15:0] i_local_port,
  output logic [7:0]  o_data,
  output logic        o_wr,
  output logic        o_sof,
  output logic        o_done,
  output logic        o_ok,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_len,
  output logic        o_busy
);
  localparam logic [3:0] S_IDLE = 4'd0, S_PRE = 4'd1, S_DMAC = 4'd2, S_SMAC = 4'd3, S_TYPE = 4'd4,
                         S_IP   = 4'd5, S_UDP = 4'd6, S_DATA = 4'd7, S_PAD  = 4'd8, S_DROP = 4'd9;
  localparam logic [15:0] LEN_MAX = 16'(MAX_PAYLOAD + 8);

  logic [3:0]  r_state;
  logic [10:0] r_cnt;
  logic [39:0] r_sh;
  logic        r_skip, r_bad, r_wrote;
  logic [47:0] r_mac;
  logic [31:0] r_ip, r_sip;
  logic [15:0] r_port, r_sport, r_ulen;
  logic [19:0] r_csum;

  logic [15:0] w_w16, w_plen, w_f2;
  logic [31:0] w_w32;
  logic [47:0] w_w48;
  logic [19:0] w_sum;
  logic [16:0] w_f1;
  logic        w_mac_ok, w_csum_ok, w_fcs_ok;

  // Field views: the current byte appended to the bytes already shifted in.
  assign w_w16     = {r_sh[7:0], i_rx_data};
  assign w_w32     = {r_sh[23:0], i_rx_data};
  assign w_w48     = {r_sh[39:0], i_rx_data};
  assign w_plen    = r_ulen - 16'd8;
  assign w_mac_ok  = (w_w48 == r_mac) || (ACCEPT_BCAST && (w_w48 == 48'hFFFF_FFFF_FFFF));
  assign w_sum     = r_csum + {4'd0, w_w16};
  assign w_f1      = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
  assign w_f2      = w_f1[15:0] + {15'd0, w_f1[16]};
  assign w_csum_ok = (w_f2 == 16'hFFFF);
  assign o_busy    = (r_state != S_IDLE);

`ifdef UDP_RECV_FCS_CHECK_EN
  logic [31:0] r_crc, w_crc_nx, w_crc_rev;
  always_comb begin
    w_crc_nx = r_crc ^ {24'd0, i_rx_data};
    for (int i = 0; i < 8; i++)
      w_crc_nx = w_crc_nx[0] ? ((w_crc_nx >> 1) ^ 32'hEDB8_8320) : (w_crc_nx >> 1);
    for (int i = 0; i < 32; i++) w_crc_rev[i] = r_crc[31-i];
  end
  always_ff @(posedge clk) begin
    if (rst || r_state == S_PRE) r_crc <= 32'hFFFF_FFFF;
    else if (i_rx_dv && r_state >= S_DMAC && r_state <= S_PAD) r_crc <= w_crc_nx;
  end
  // Residue is given in normal bit order; the register runs reflected. PAD must hold the FCS.
  assign w_fcs_ok = (w_crc_rev == 32'hC704_DD7B) && r_cnt[2];
`else
  assign w_fcs_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE; r_cnt <= '0; r_sh <= '0; r_skip <= 1'b0; r_bad <= 1'b0; r_wrote <= 1'b0;
      r_mac <= '0; r_ip <= '0; r_port <= '0; r_sip <= '0; r_sport <= '0; r_ulen <= '0; r_csum <= '0;
      o_data <= '0; o_wr <= 1'b0; o_sof <= 1'b0; o_done <= 1'b0; o_ok <= 1'b0;
      o_src_ip <= '0; o_src_port <= '0; o_len <= '0;
    end else begin
      o_wr <= 1'b0; o_sof <= 1'b0; o_done <= 1'b0; o_ok <= 1'b0;
      if (!i_rx_dv) begin
        if (r_state == S_DATA || r_state == S_PAD) begin
          o_done <= r_wrote;
          o_ok   <= r_wrote && (r_state == S_PAD) && w_fcs_ok;
        end
        r_state <= S_IDLE; r_skip <= 1'b0; r_wrote <= 1'b0;
      end else begin
        r_sh  <= {r_sh[31:0], i_rx_data};
        r_cnt <= r_cnt + 11'd1;
        case (r_state)
          S_IDLE: if (!r_skip) begin
            if (i_rx_data == 8'h55) r_state <= S_PRE;
            else                    r_skip  <= 1'b1;
          end
          S_PRE: if (i_rx_data == 8'hD5) begin
            r_state <= S_DMAC; r_cnt <= '0;
            r_mac <= i_local_mac; r_ip <= i_local_ip; r_port <= i_local_port;
          end else if (i_rx_data != 8'h55) r_state <= S_DROP;
          S_DMAC: if (r_cnt == 11'd5) begin
            r_cnt <= '0; r_state <= w_mac_ok ? S_SMAC : S_DROP;
          end
          S_SMAC: if (r_cnt == 11'd5) begin
            r_cnt <= '0; r_state <= S_TYPE;
          end
          S_TYPE: if (r_cnt == 11'd1) begin
            r_cnt <= '0; r_csum <= '0; r_bad <= 1'b0;
            r_state <= (w_w16 == 16'h0800) ? S_IP : S_DROP;
          end
          S_IP: begin
            if (r_cnt[0]) r_csum <= w_sum;
            case (r_cnt)
              11'd0:  if (i_rx_data != 8'h45) r_bad <= 1'b1;
              11'd7:  if (w_w16[13:0] != 14'd0) r_bad <= 1'b1;  // MF flag or fragment offset
              11'd9:  if (i_rx_data != 8'd17) r_bad <= 1'b1;
              11'd15: r_sip <= w_w32;
              11'd19: begin
                r_cnt <= '0; r_bad <= 1'b0;
                r_state <= (!r_bad && w_w32 == r_ip && w_csum_ok) ? S_UDP : S_DROP;
              end
              default: ;
            endcase
          end
          S_UDP: case (r_cnt)
            11'd1: r_sport <= w_w16;
            11'd3: if (w_w16 != r_port) r_bad <= 1'b1;
            11'd5: r_ulen <= w_w16;
            11'd7: begin
              r_cnt <= '0;
              if (r_bad || r_ulen < 16'd8 || r_ulen > LEN_MAX) r_state <= S_DROP;
              else if (r_ulen == 16'd8)                         r_state <= S_PAD;
              else                                              r_state <= S_DATA;
            end
            default: ;
          endcase
          S_DATA: begin
            o_wr <= 1'b1; o_data <= i_rx_data; r_wrote <= 1'b1;
            if (r_cnt == 11'd0) begin
              o_sof <= 1'b1; o_len <= w_plen; o_src_ip <= r_sip; o_src_port <= r_sport;
            end
            if ({5'd0, r_cnt} == w_plen - 16'd1) begin
              r_cnt <= '0; r_state <= S_PAD;
            end
          end
          S_PAD: if (r_cnt[2]) r_cnt <= r_cnt;  // saturate once 4 trailing bytes are seen
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_udp_recv.sv
// Self-checking bench for udp_recv: directed and randomized frames against a frame-level model.
module tb_udp_recv;
`ifdef UDP_RECV_FCS_CHECK_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif
  localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
  localparam logic [31:0] LIP   = 32'hC0A8_0164;
  localparam logic [15:0] LPORT = 16'd1234;
  localparam int HDR = 50;  // preamble+SFD+MAC+IP+UDP bytes before payload

  logic clk = 1'b0, rst = 1'b1, rx_dv = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] o_data, o_data0;
  logic o_wr, o_sof, o_done, o_ok, o_busy, o_wr0, o_sof0, o_done0, o_ok0, o_busy0;
  logic [31:0] o_src_ip, o_src_ip0;
  logic [15:0] o_src_port, o_len, o_src_port0, o_len0;

  always #5 clk = ~clk;

  udp_recv #(.MAX_PAYLOAD(1472), .ACCEPT_BCAST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_dv(rx_dv),
    .i_local_mac(LMAC), .i_local_ip(LIP), .i_local_port(LPORT),
    .o_data(o_data), .o_wr(o_wr), .o_sof(o_sof), .o_done(o_done), .o_ok(o_ok),
    .o_src_ip(o_src_ip), .o_src_port(o_src_port), .o_len(o_len), .o_busy(o_busy));

  udp_recv #(.MAX_PAYLOAD(1472), .ACCEPT_BCAST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_dv(rx_dv),
    .i_local_mac(LMAC), .i_local_ip(LIP), .i_local_port(LPORT),
    .o_data(o_data0), .o_wr(o_wr0), .o_sof(o_sof0), .o_done(o_done0), .o_ok(o_ok0),
    .o_src_ip(o_src_ip0), .o_src_port(o_src_port0), .o_len(o_len0), .o_busy(o_busy0));

  typedef struct {
    logic [47:0] dmac;
    logic [15:0] etype, frag, sport, dport, ulen, ck_xor;
    logic [7:0]  vihl, proto;
    logic [31:0] sip, dip;
    int          plen, corrupt;
    bit          seq;
  } fr_t;

  int checks = 0, failures = 0;
  logic [7:0] frm[$], pay[$], got[$];
  int sof_cnt = 0, done_cnt = 0, ok_cnt = 0, order_err = 0, wr0_cnt = 0, done0_cnt = 0;
  logic [15:0] len_snap = '0, port_snap = '0;
  logic [31:0] ip_snap = '0;
  bit done_since_sof = 1'b0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_wr) begin
      got.push_back(o_data);
      if (!o_sof && done_since_sof) order_err++;
    end
    if (o_sof) begin
      if (!o_wr) order_err++;
      sof_cnt++; done_since_sof = 1'b0;
      len_snap = o_len; ip_snap = o_src_ip; port_snap = o_src_port;
    end
    if (o_done) begin
      done_cnt++; done_since_sof = 1'b1;
      if (o_ok) ok_cnt++;
    end
    if (o_wr0)   wr0_cnt++;
    if (o_done0) done0_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic fr_t good_fr(input int plen, input bit seq);
    fr_t f;
    f.dmac = LMAC; f.etype = 16'h0800; f.vihl = 8'h45; f.proto = 8'd17; f.frag = 16'h4000;
    f.sip = $urandom; f.dip = LIP; f.sport = 16'($urandom); f.dport = LPORT;
    f.ulen = 16'(plen + 8); f.ck_xor = 16'd0; f.plen = plen; f.corrupt = -1; f.seq = seq;
    return f;
  endfunction

  // Reference acceptance rule for a frame at the field level.
  function automatic bit accepts(input fr_t f, input bit bc);
    return ((f.dmac == LMAC) || (bc && f.dmac == 48'hFFFF_FFFF_FFFF)) && f.etype == 16'h0800 &&
           f.vihl == 8'h45 && f.proto == 8'd17 && (f.frag & 16'h3FFF) == 16'd0 && f.dip == LIP &&
           f.ck_xor == 16'd0 && f.dport == LPORT && f.ulen >= 16'd8 && f.ulen <= 16'd1480;
  endfunction

  task automatic build(input fr_t f);
    logic [7:0] b[$];
    logic [7:0] ip[20];
    logic [15:0] tot, ck;
    logic [31:0] c;
    logic [47:0] smac;
    int s;
    smac = 48'h0211_2233_4455;
    pay = {};
    for (int i = 0; i < f.plen; i++) pay.push_back(f.seq ? 8'(i) : 8'($urandom));
    tot = f.ulen + 16'd20;
    ip = '{f.vihl, 8'h00, tot[15:8], tot[7:0], 8'h12, 8'h34, f.frag[15:8], f.frag[7:0], 8'h40, f.proto,
           8'h00, 8'h00, f.sip[31:24], f.sip[23:16], f.sip[15:8], f.sip[7:0],
           f.dip[31:24], f.dip[23:16], f.dip[15:8], f.dip[7:0]};
    s = 0;
    for (int k = 0; k < 10; k++) s += int'({ip[2*k], ip[2*k+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~(16'(s)) ^ f.ck_xor;
    ip[10] = ck[15:8]; ip[11] = ck[7:0];
    b = {};
    for (int i = 5; i >= 0; i--) b.push_back(f.dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(smac[8*i +: 8]);
    b.push_back(f.etype[15:8]); b.push_back(f.etype[7:0]);
    foreach (ip[i]) b.push_back(ip[i]);
    b.push_back(f.sport[15:8]); b.push_back(f.sport[7:0]);
    b.push_back(f.dport[15:8]); b.push_back(f.dport[7:0]);
    b.push_back(f.ulen[15:8]);  b.push_back(f.ulen[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    foreach (pay[i]) b.push_back(pay[i]);
    while (b.size() < 60) b.push_back(8'h00);
    c = crc32(b);
    b.push_back(c[7:0]); b.push_back(c[15:8]); b.push_back(c[23:16]); b.push_back(c[31:24]);
    if (f.corrupt >= 0) begin
      b[42+f.corrupt] ^= 8'hFF;
      pay[f.corrupt]  ^= 8'hFF;
    end
    frm = {};
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    foreach (b[i]) frm.push_back(b[i]);
  endtask

  task automatic send(input int n, input int gap, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rx_dv = 1'b1; rx_data = frm[i];
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run(input fr_t f, input int n_in, input string tag);
    int n, sp, ew, ew0, wb, db, ob, sb, w0b, d0b, oeb, mism;
    bit eok;
    build(f);
    n  = (n_in < 0) ? frm.size() : n_in;
    sp = n - HDR;
    if (sp < 0) sp = 0;
    if (sp > int'(f.ulen) - 8) sp = int'(f.ulen) - 8;
    ew  = accepts(f, 1'b1) ? sp : 0;
    ew0 = accepts(f, 1'b0) ? sp : 0;
    eok = (n == frm.size()) && (!FCS || f.corrupt < 0);
    wb = got.size(); db = done_cnt; ob = ok_cnt; sb = sof_cnt; w0b = wr0_cnt; d0b = done0_cnt; oeb = order_err;
    send(n, 1, -1);
    repeat (3) @(negedge clk);
    chk({tag, "_wr"}, 64'(got.size() - wb), 64'(ew));
    mism = 0;
    for (int i = 0; i < ew && wb + i < got.size(); i++) if (got[wb+i] !== pay[i]) mism++;
    chk({tag, "_data"}, 64'(mism), 64'd0);
    chk({tag, "_done"}, 64'(done_cnt - db), (ew > 0) ? 64'd1 : 64'd0);
    chk({tag, "_ok"}, 64'(ok_cnt - ob), (ew > 0 && eok) ? 64'd1 : 64'd0);
    chk({tag, "_sof"}, 64'(sof_cnt - sb), (ew > 0) ? 64'd1 : 64'd0);
    if (ew > 0) begin
      chk({tag, "_len"}, 64'(len_snap), 64'(f.ulen - 16'd8));
      chk({tag, "_sip"}, 64'(ip_snap), 64'(f.sip));
      chk({tag, "_sport"}, 64'(port_snap), 64'(f.sport));
    end
    chk({tag, "_order"}, 64'(order_err - oeb), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_wr_nobc"}, 64'(wr0_cnt - w0b), 64'(ew0));
    chk({tag, "_done_nobc"}, 64'(done0_cnt - d0b), (ew0 > 0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    fr_t f;
    int wb, db, ob, e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({o_wr, o_sof, o_done, o_ok, o_busy, o_data}), 64'd0);
    chk("rst_fld", 64'({o_len, o_src_ip, o_src_port}), 64'd0);
    rst = 1'b0;

    f = good_fr(10, 1'b1);                     run(f, -1, "t1_good");
    f = good_fr(10, 1'b1); f.dip = LIP + 1;    run(f, -1, "t2_ip");
    f = good_fr(10, 1'b1); f.dport = 16'd1235; run(f, -1, "t2_port");
    f = good_fr(10, 1'b1); f.ck_xor = 16'h0001; run(f, -1, "t3_csum");
    f = good_fr(100, 1'b0);                    run(f, HDR + 5, "t4_trunc");
    f = good_fr(20, 1'b0);                     run(f, -1, "t4_next");
    f = good_fr(10, 1'b1); f.corrupt = 3;      run(f, -1, "t5_fcs");

    // Reset asserted while payload is streaming.
    f = good_fr(40, 1'b1);
    build(f);
    wb = got.size(); db = done_cnt;
    send(frm.size(), 1, HDR + 7);
    chk("t6_rst_ctl", 64'({o_wr, o_sof, o_done, o_ok, o_busy, o_data}), 64'd0);
    chk("t6_rst_fld", 64'({o_len, o_src_ip, o_src_port}), 64'd0);
    repeat (5) @(negedge clk);
    chk("t6_rst_wr", 64'(got.size() - wb), 64'd7);
    chk("t6_rst_done", 64'(done_cnt - db), 64'd0);
    f = good_fr(12, 1'b0);                     run(f, -1, "t6_after");
    f = good_fr(10, 1'b1); f.dmac = 48'hFFFF_FFFF_FFFF; run(f, -1, "t6_bcast");

    f = good_fr(0, 1'b0);                      run(f, -1, "len8");
    f = good_fr(0, 1'b0); f.ulen = 16'd7;      run(f, -1, "len7");
    f = good_fr(0, 1'b0); f.ulen = 16'd1481;   run(f, -1, "len1481");
    f = good_fr(1472, 1'b0);                   run(f, -1, "len_max");

    // Back-to-back frames separated by a single idle cycle.
    f = good_fr(12, 1'b1);
    build(f);
    wb = got.size(); db = done_cnt; ob = ok_cnt;
    send(frm.size(), 1, -1);
    send(frm.size(), 1, -1);
    repeat (3) @(negedge clk);
    chk("b2b_wr", 64'(got.size() - wb), 64'd24);
    chk("b2b_done", 64'(done_cnt - db), 64'd2);
    chk("b2b_ok", 64'(ok_cnt - ob), 64'd2);

    for (int it = 0; it < 12; it++) begin
      e = $urandom_range(0, 11);
      f = good_fr($urandom_range(1, 48), 1'b0);
      case (e)
        1:  f.dmac = {16'h0200, 32'($urandom)};
        2:  f.dmac = 48'hFFFF_FFFF_FFFF;
        3:  f.etype = 16'h86DD;
        4:  f.vihl = 8'h46;
        5:  f.proto = 8'd6;
        6:  f.frag = 16'h2000;
        7:  f.frag = 16'(16'h0001 | 16'($urandom_range(0, 8191)));
        8:  f.dip = LIP ^ (32'd1 << $urandom_range(0, 31));
        9:  f.dport = LPORT ^ (16'd1 << $urandom_range(0, 15));
        10: f.ck_xor = 16'($urandom_range(1, 16'hFFFE));
        11: f.corrupt = $urandom_range(0, f.plen - 1);
        default: ;
      endcase
      run(f, -1, $sformatf("rnd%0d_e%0d", it, e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
